// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per clock, unsigned or signed per transaction.
// Optional SEQ_MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module seq_shift_add_multiplier #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           is_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg, state_next;
  logic [2*N-1:0] mcand_reg, mcand_next;
  logic [2*N-1:0] acc_reg, acc_next;
  logic [2*N-1:0] product_reg, product_next;
  logic [N-1:0]   mplier_reg, mplier_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           neg_reg, neg_next;

  logic [N-1:0]   a_mag, b_mag;
  logic [2*N-1:0] acc_sum;
  logic           last_step;

  // The most negative value maps to 2^(N-1), which still fits in N unsigned bits.
  assign a_mag   = (is_signed && a[N-1]) ? -a : a;
  assign b_mag   = (is_signed && b[N-1]) ? -b : b;
  assign acc_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

`ifdef SEQ_MUL_EARLY_TERM_EN
  assign last_step = (cnt_reg == CW'(N-1)) || (mplier_reg[N-1:1] == '0);
`else
  assign last_step = (cnt_reg == CW'(N-1));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      mcand_reg   <= '0;
      acc_reg     <= '0;
      product_reg <= '0;
      mplier_reg  <= '0;
      cnt_reg     <= '0;
      neg_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mcand_reg   <= mcand_next;
      acc_reg     <= acc_next;
      product_reg <= product_next;
      mplier_reg  <= mplier_next;
      cnt_reg     <= cnt_next;
      neg_reg     <= neg_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    mcand_next   = mcand_reg;
    acc_next     = acc_reg;
    product_next = product_reg;
    mplier_next  = mplier_reg;
    cnt_next     = cnt_reg;
    neg_next     = neg_reg;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mcand_next  = {{N{1'b0}}, a_mag};
          mplier_next = b_mag;
          neg_next    = is_signed & (a[N-1] ^ b[N-1]);
          cnt_next    = '0;
          acc_next    = '0;
          state_next  = RUN;
        end
      end
      RUN: begin
        busy        = 1'b1;
        acc_next    = acc_sum;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + CW'(1);
        if (last_step) begin
          product_next = neg_reg ? -acc_sum : acc_sum;
          state_next   = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign product = product_reg;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench: N=4 directed cases and an N=8 randomized sweep against an arithmetic model.
module tb_seq_shift_add_multiplier;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       iv4 = 1'b0, ir4, s4 = 1'b0, ov4, or4 = 1'b0, busy4;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] p4;

  logic        iv8 = 1'b0, ir8, s8 = 1'b0, ov8, or8 = 1'b0, busy8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;

  int checks = 0;
  int failures = 0;

`ifdef SEQ_MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  always #5 clk = ~clk;

  seq_shift_add_multiplier #(.N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .is_signed(s4), .out_valid(ov4), .out_ready(or4), .product(p4), .busy(busy4)
  );

  seq_shift_add_multiplier #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .is_signed(s8), .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer multiply of the operands as interpreted by the mode.
  function automatic longint exp_prod(input int n, input longint av, input longint bv, input bit s);
    longint mask = (longint'(1) << n) - 1;
    longint x = av & mask;
    longint y = bv & mask;
    if (s && x[n-1]) x = x - (longint'(1) << n);
    if (s && y[n-1]) y = y - (longint'(1) << n);
    return (x * y) & ((longint'(1) << (2 * n)) - 1);
  endfunction

  function automatic int exp_lat(input int n, input longint bv, input bit s);
    longint m = bv & ((longint'(1) << n) - 1);
    int hi = -1;
    if (s && m[n-1]) m = (longint'(1) << n) - m;
    for (int i = 0; i < n; i++) if (m[i]) hi = i;
    if (EARLY) return (hi + 1 < 1) ? 1 : hi + 1;
    return n;
  endfunction

  task automatic drive(input int n, input bit iv, input longint av, input longint bv,
                       input bit s, input bit ordy);
    if (n == 4) begin
      iv4 = iv; a4 = av[3:0]; b4 = bv[3:0]; s4 = s; or4 = ordy;
    end else begin
      iv8 = iv; a8 = av[7:0]; b8 = bv[7:0]; s8 = s; or8 = ordy;
    end
  endtask

  function automatic logic [63:0] get_prod(input int n);
    return (n == 4) ? 64'(p4) : 64'(p8);
  endfunction
  function automatic logic get_ov(input int n);
    return (n == 4) ? ov4 : ov8;
  endfunction
  function automatic logic get_ir(input int n);
    return (n == 4) ? ir4 : ir8;
  endfunction
  function automatic logic get_busy(input int n);
    return (n == 4) ? busy4 : busy8;
  endfunction

  // One transaction; stall<0 gives random out_ready, otherwise stall cycles of back-pressure.
  task automatic run_txn(input int n, input longint av, input longint bv, input bit s,
                         input int stall, input string tag);
    longint ep = exp_prod(n, av, bv, s);
    int el = exp_lat(n, bv, s);
    int lat = 0;
    int st = 0;
    bit done = 1'b0;
    bit r;
    drive(n, 1'b1, av, bv, s, 1'b0);
    check_val({tag, "_in_ready"}, 64'(get_ir(n)), 64'd1);
    @(posedge clk); #1;
    check_val({tag, "_busy"}, 64'(get_busy(n)), 64'd1);
    // Junk operands and in_valid pulses while busy must not disturb the result.
    while (!get_ov(n) && lat < 4 * n + 4) begin
      drive(n, 1'($urandom % 2), $urandom, $urandom, 1'($urandom % 2), 1'($urandom % 2));
      @(posedge clk); #1;
      lat++;
    end
    check_val({tag, "_latency"}, 64'(lat), 64'(el));
    while (!done && st < 64) begin
      check_val({tag, "_product"}, get_prod(n), ep);
      r = (stall < 0) ? 1'($urandom % 2) : (st >= stall);
      drive(n, 1'($urandom % 2), $urandom, $urandom, 1'($urandom % 2), r);
      @(posedge clk); #1;
      st++;
      if (r) done = 1'b1;
    end
    drive(n, 1'b0, 0, 0, 1'b0, 1'b0);
    check_val({tag, "_ov_clear"}, 64'(get_ov(n)), 64'd0);
    check_val({tag, "_retain"}, get_prod(n), ep);
    $display("txn %s n=%0d a=%0d b=%0d signed=%0d product=0x%0h latency=%0d", tag, n, av & 64'hFF,
             bv & 64'hFF, s, get_prod(n), lat);
  endtask

  initial begin
    bit seen_ov;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready4", 64'(ir4), 64'd1);
    check_val("rst_out_valid4", 64'(ov4), 64'd0);
    check_val("rst_busy4", 64'(busy4), 64'd0);
    check_val("rst_product4", 64'(p4), 64'd0);
    check_val("rst_in_ready8", 64'(ir8), 64'd1);
    check_val("rst_out_valid8", 64'(ov8), 64'd0);
    check_val("rst_product8", 64'(p8), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn(4, 13, 11, 1'b0, 5, "u13x11");
    check_val("u13x11_const", 64'(p4), 64'h8F);
    run_txn(4, 8, 7, 1'b1, 0, "sm8x7");
    check_val("sm8x7_const", 64'(p4), 64'hC8);
    run_txn(4, 8, 8, 1'b1, 1, "sm8xm8");
    check_val("sm8xm8_const", 64'(p4), 64'h40);
    run_txn(4, 15, 15, 1'b0, 0, "u15x15");

    // Abort a transaction with reset on its second RUN cycle.
    drive(4, 1'b1, 15, 15, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(4, 1'b0, 0, 0, 1'b0, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_val("abort_in_ready", 64'(ir4), 64'd1);
    check_val("abort_busy", 64'(busy4), 64'd0);
    check_val("abort_product", 64'(p4), 64'd0);
    seen_ov = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen_ov = seen_ov | ov4;
      @(posedge clk); #1;
    end
    check_val("abort_no_ov", 64'(seen_ov), 64'd0);
    drive(4, 1'b0, 0, 0, 1'b0, 1'b0);
    run_txn(4, 3, 5, 1'b0, 0, "post_rst");
    check_val("post_rst_const", 64'(p4), 64'd15);

    run_txn(8, 123, 0, 1'b0, 0, "b0");
    run_txn(8, 200, 1, 1'b0, 0, "a200b1");
    run_txn(8, 77, 8'h80, 1'b0, 0, "b80u");
    run_txn(8, 8'h80, 8'h80, 1'b1, 0, "m128sq");
    run_txn(8, 8'hFF, 8'hFF, 1'b0, 0, "ffsq");

    for (int i = 0; i < 1000; i++)
      run_txn(8, $urandom, $urandom, 1'($urandom % 2), -1, $sformatf("rnd%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
